systolic_feed_ctrl: RTL

//  Tile sequencer for the systolic weight/data feed path. Per tile it drives the 7-bit addr_serial_num

---
 rtl/systolic_feed_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - tile sequencer for the systolic weight/data feed path
// Per tile: clear accumulators, stream serial codes, drain the array, hand off the result.
module systolic_feed_ctrl #(
  parameter int SERIAL_MAX   = 126,
  parameter int DRAIN_CYCLES = 32,
  parameter int FEED_LAT     = 2,
  parameter int TILE_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              hold,
  output logic [6:0]        addr_serial_num,
  output logic              acc_clear,
  output logic              feed_valid,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [6:0]    IDLE_CODE   = 7'd127;
  localparam logic [6:0]    SERIAL_LAST = 7'(SERIAL_MAX);
  localparam logic [DW-1:0] DRAIN_LOAD  = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_DRAIN, S_WB} state_t;

  state_t            state, state_next;
  logic [6:0]        addr_next;
  logic [DW-1:0]     drain_cnt, drain_cnt_next;
  logic [TILE_W-1:0] tiles_lat, tiles_lat_next, tile_idx_next;
  logic              done_next;
  logic              feed_in;
  logic [FEED_LAT-1:0] feed_pipe;

  // Mirrors the selector register + SRAM read, so feed_valid lines up with operands.
  assign feed_in    = (state == S_FEED) && !hold;
  assign feed_valid = feed_pipe[FEED_LAT-1];

  always_comb begin
    state_next     = state;
    addr_next      = IDLE_CODE;
    drain_cnt_next = drain_cnt;
    tiles_lat_next = tiles_lat;
    tile_idx_next  = tile_idx;
    done_next      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_tiles != '0) begin
            tiles_lat_next = num_tiles;
            tile_idx_next  = '0;
            state_next     = S_CLR;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      S_CLR: begin
        state_next = S_FEED;
        addr_next  = 7'd0;
      end
      S_FEED: begin
        addr_next = addr_serial_num;
        if (!hold) begin
          if (addr_serial_num == SERIAL_LAST) begin
            state_next     = S_DRAIN;
            addr_next      = IDLE_CODE;
            drain_cnt_next = DRAIN_LOAD;
          end else begin
            addr_next = addr_serial_num + 7'd1;
          end
        end
      end
      S_DRAIN: begin
        if (!hold) begin
          if (drain_cnt == '0) begin
            state_next = S_WB;
          end else begin
            drain_cnt_next = drain_cnt - DW'(1);
          end
        end
      end
      S_WB: begin
        if (result_ready) begin
          if (tile_idx == tiles_lat - TILE_W'(1)) begin
            state_next    = S_IDLE;
            tile_idx_next = '0;
            done_next     = 1'b1;
          end else begin
            tile_idx_next = tile_idx + TILE_W'(1);
            state_next    = S_CLR;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they align with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      addr_serial_num <= IDLE_CODE;
      drain_cnt       <= '0;
      tiles_lat       <= '0;
      tile_idx        <= '0;
      feed_pipe       <= '0;
      acc_clear       <= 1'b0;
      result_valid    <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_next;
      addr_serial_num <= addr_next;
      drain_cnt       <= drain_cnt_next;
      tiles_lat       <= tiles_lat_next;
      tile_idx        <= tile_idx_next;
      feed_pipe       <= (feed_pipe << 1) | FEED_LAT'(feed_in);
      acc_clear       <= (state_next == S_CLR);
      result_valid    <= (state_next == S_WB);
      busy            <= (state_next != S_IDLE);
      done            <= done_next;
    end
  end

endmodule
